gate_sweep_ctrl: RTL and testbench

Hardware stimulus sequencer and checker for any 2-input logic gate (xnor_gate, and/or/xor family) in the gate library. On start, it drives the gate under test through all four input combinations {a,b} = 00, 01, 10, 11, holding each for a programmable number of cycles. At the end of each hold it samples the gate output and compares it against a 4-bit expected truth table. It reports pass/fail with a per-vector mismatch mask, and serves as the on-chip self-check for combinational gate blocks.

---
 rtl/gate_test_pkg.sv | 10 +
 rtl/hold_timer.sv | 18 +
 rtl/gate_sweep_ctrl.sv | 81 ++++++++
 tb/tb_gate_sweep_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM encoding and 2-input gate truth tables, indexed by {a,b}
package gate_test_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter flagging the last cycle of a vector hold
module hold_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en) cnt <= cnt - 1'b1;
   assign zero = cnt == '0;
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps a 2-input gate through all input vectors and checks it against a truth table
module gate_sweep_ctrl
   import gate_test_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] exp_tt,
   input  logic       dut_y,
   output logic       dut_a,
   output logic       dut_b,
   output logic [1:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_mask
);
   state_t     state;
   logic [3:0] tt_q;
   logic [3:0] err_upd;
   logic       zero;
   logic       load;
   assign load = (state == IDLE && start) || (state == DRIVE && !abort && zero && vec_idx != 2'd3);
   hold_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (CNT_W'(HOLD_CYCLES - 1)),
      .en       (state == DRIVE),
      .zero     (zero)
   );
   always_comb begin
      err_upd = err_mask;
      err_upd[vec_idx] = dut_y != tt_q[vec_idx];
   end
   // vec_idx is a register, so the gate inputs it drives are registered too
   assign dut_a = vec_idx[1];
   assign dut_b = vec_idx[0];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         tt_q     <= '0;
         vec_idx  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_mask <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               tt_q     <= exp_tt;
               err_mask <= '0;
               pass     <= 1'b0;
               vec_idx  <= '0;
               busy     <= 1'b1;
               state    <= DRIVE;
            end
            DRIVE: if (abort) begin
               state   <= IDLE;
               vec_idx <= '0;
               busy    <= 1'b0;
            end else if (zero) begin
               err_mask <= err_upd;
               if (vec_idx == 2'd3) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  pass    <= ~|err_upd;
                  busy    <= 1'b0;
                  vec_idx <= '0;
               end else vec_idx <= vec_idx + 2'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: table-driven and randomized checks of gate_sweep_ctrl at HOLD_CYCLES 4 and 1
module tb_gate_sweep_ctrl;
   import gate_test_pkg::*;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start4 = 1'b0, start1 = 1'b0, abort = 1'b0;
   logic [3:0] exp_tt = '0, act_tt = '0;
   logic       a4, b4, busy4, done4, pass4, a1, b1, busy1, done1, pass1;
   logic [1:0] vec4, vec1;
   logic [3:0] err4, err1;
   logic       y4, y1;
   bit         cur = 1'b0;
   int         checks = 0, errors = 0;
   logic       oa, ob, obusy, odone, opass;
   logic [1:0] ovec;
   logic [3:0] oerr;
   assign y4 = act_tt[{a4, b4}];
   assign y1 = act_tt[{a1, b1}];
   assign oa = cur ? a1 : a4;
   assign ob = cur ? b1 : b4;
   assign obusy = cur ? busy1 : busy4;
   assign odone = cur ? done1 : done4;
   assign opass = cur ? pass1 : pass4;
   assign ovec = cur ? vec1 : vec4;
   assign oerr = cur ? err1 : err4;
   always #5 clk = ~clk;
   gate_sweep_ctrl #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .exp_tt(exp_tt), .dut_y(y4),
      .dut_a(a4), .dut_b(b4), .vec_idx(vec4), .busy(busy4), .done(done4), .pass(pass4), .err_mask(err4)
   );
   gate_sweep_ctrl #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .exp_tt(exp_tt), .dut_y(y1),
      .dut_a(a1), .dut_b(b1), .vec_idx(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_mask(err1)
   );
   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, want);
      end
   endtask
   task automatic set_start(input bit s, input logic v);
      if (s) start1 = v;
      else start4 = v;
   endtask
   task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
         chk("idle_done", 8'(odone), 8'd0);
         chk("idle_busy", 8'(obusy), 8'd0);
         @(negedge clk);
      end
   endtask
   // mode: 0 full sweep, 1 abort in cycle cut, 2 reset in cycle cut; poke re-asserts start mid-run and on done
   task automatic sweep(input bit s, input logic [3:0] e, input logic [3:0] act, input logic [3:0] xerr,
                        input bit xpass, input int mode, input int cut, input bit poke);
      int h;
      int nv;
      logic [3:0] part;
      h = s ? 1 : 4;
      cur = s;
      exp_tt = e;
      act_tt = act;
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      exp_tt = ~e;
      for (int k = 1; k <= 4 * h; k++) begin
         nv = (k - 1) / h;
         part = xerr & 4'((1 << nv) - 1);
         chk("vec_idx", 8'(ovec), 8'(nv));
         chk("dut_ab", 8'({oa, ob}), 8'(nv));
         chk("busy", 8'(obusy), 8'd1);
         chk("done_early", 8'(odone), 8'd0);
         chk("err_partial", 8'(oerr), 8'(part));
         if (mode != 0 && k == cut) begin
            if (mode == 1) abort = 1'b1;
            else rst_n = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            rst_n = 1'b1;
            chk("cut_ab", 8'({oa, ob}), 8'd0);
            chk("cut_vec", 8'(ovec), 8'd0);
            chk("cut_pass", 8'(opass), 8'd0);
            chk("cut_err", 8'(oerr), mode == 1 ? 8'(part) : 8'd0);
            idle_chk(6);
            return;
         end
         set_start(s, poke && k == 3);
         @(negedge clk);
      end
      set_start(s, 1'b0);
      chk("done", 8'(odone), 8'd1);
      chk("done_busy", 8'(obusy), 8'd0);
      chk("done_ab", 8'({oa, ob, ovec}), 8'd0);
      chk("pass", 8'(opass), 8'(xpass));
      chk("err_mask", 8'(oerr), 8'(xerr));
      set_start(s, poke);
      @(negedge clk);
      set_start(s, 1'b0);
      chk("pass_hold", 8'(opass), 8'(xpass));
      chk("err_hold", 8'(oerr), 8'(xerr));
      idle_chk(6);
      chk("pass_hold2", 8'(opass), 8'(xpass));
   endtask
   typedef struct {
      bit         s;
      logic [3:0] e;
      logic [3:0] act;
      logic [3:0] xerr;
      bit         xpass;
   } vec_t;
   vec_t tbl[6];
   initial begin
      tbl[0] = '{0, TT_XNOR, TT_XNOR, 4'b0000, 1'b1};
      tbl[1] = '{0, TT_XNOR, 4'b0000, 4'b1001, 1'b0};
      tbl[2] = '{1, TT_AND,  TT_AND,  4'b0000, 1'b1};
      tbl[3] = '{0, TT_OR,   TT_XOR,  4'b1000, 1'b0};
      tbl[4] = '{1, TT_NAND, TT_NOR,  4'b0110, 1'b0};
      tbl[5] = '{0, TT_XOR,  TT_XOR,  4'b0000, 1'b1};
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         cur = d[0];
         chk("rst_out", 8'({oa, ob, ovec, obusy, odone, opass}), 8'd0);
         chk("rst_err", 8'(oerr), 8'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      foreach (tbl[i]) sweep(tbl[i].s, tbl[i].e, tbl[i].act, tbl[i].xerr, tbl[i].xpass, 0, 0, 1'b0);
      sweep(0, TT_XNOR, TT_XNOR, 4'b0000, 1'b1, 0, 0, 1'b1);
      sweep(0, TT_XNOR, 4'b0000, 4'b0001, 1'b0, 1, 6, 1'b0);
      sweep(0, TT_XNOR, TT_XNOR, 4'b0000, 1'b1, 0, 0, 1'b0);
      sweep(0, TT_XNOR, 4'b0000, 4'b1001, 1'b0, 2, 10, 1'b0);
      sweep(0, TT_XNOR, 4'b0000, 4'b1001, 1'b0, 0, 0, 1'b0);
      sweep(1, TT_AND, TT_AND, 4'b0000, 1'b1, 1, 4, 1'b0);
      for (int r = 0; r < 12; r++) begin
         logic [3:0] e, act;
         e = 4'($urandom);
         act = ($urandom_range(0, 2) == 0) ? e : 4'($urandom);
         sweep(1'($urandom), e, act, e ^ act, e == act, 0, 0, 1'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
